game_flow_ctrl: RTL and testbench
=================================

Name: game_flow_ctrl

Overview:
- Game-level sequencer for the pong design. It owns the score and life counters and runs the serve/play/miss/game-over flow.
- Sits between the ball/paddle collision logic and the on-screen score/life text renderer. It drives the renderer's 4-bit score input and the lives value.
- Gates ball motion through ball_run and ball_rst, so the ball only moves while a rally is live.

Parameters:
- LIVES_INIT, 3, lives loaded at game start (1..3).
- SCORE_MAX, 9, score value that ends the game with a win (1..9, one decimal digit).
- SERVE_FRAMES, 60, frame ticks the ball is held before a serve.
- MISS_FRAMES, 90, frame ticks of pause after a miss.

Ports:
- clk  in  1  system pixel clock
- rst_n  in  1  asynchronous active-low reset
- frame_tick  in  1  one-cycle pulse once per video frame
- start_btn  in  1  debounced start button, level
- hit  in  1  paddle-hit level from collision logic
- miss  in  1  ball-past-paddle level from collision logic
- score  out  4  current score, binary 0..SCORE_MAX
- lives  out  2  remaining lives, 0..3
- ball_run  out  1  ball may move
- ball_rst  out  1  one-cycle pulse: recentre the ball
- game_over  out  1  high in OVER or WIN
- win  out  1  high in WIN only
- state  out  3  current FSM state encoding, for debug

Behaviour:
- Reset (async, rst_n=0) values:
  - state=IDLE, score=0, lives=LIVES_INIT
  - ball_run=0, ball_rst=0, game_over=0, win=0
  - frame counter=0, all edge-detect registers=0
- Edge detection:
  - start_btn, hit and miss are each registered once. An event is the rising edge (current=1, previous=0).
  - Levels held high for many cycles count once.
- FSM states and encodings: IDLE=0, SERVE=1, PLAY=2, MISS=3, OVER=4, WIN=5. Unused codes go to IDLE on the next clock.
- IDLE: start event -> SERVE. In the same transition: score=0, lives=LIVES_INIT, ball_rst pulses 1 cycle.
- SERVE:
  - The frame counter counts frame_tick.
  - When the counter reaches SERVE_FRAMES -> PLAY and the counter clears.
  - hit, miss and start events are ignored.
- PLAY (ball_run=1):
  - hit event with score < SCORE_MAX-1 -> score+1, stay in PLAY.
  - hit event with score == SCORE_MAX-1 -> score=SCORE_MAX, go to WIN.
  - miss event -> lives-1.
    - If the new lives value is 0 -> OVER.
    - Otherwise -> MISS.
  - A hit and a miss event in the same cycle: miss takes priority and the hit is discarded.
- MISS:
  - ball_run=0, count MISS_FRAMES frame ticks.
  - Then -> SERVE with a ball_rst pulse.
  - Score is held.
- OVER / WIN:
  - ball_run=0, game_over=1 (win=1 in WIN only).
  - score and lives are frozen.
  - start event -> the IDLE->SERVE action (counters reloaded, ball_rst pulse).
- Output timing:
  - All outputs are registered.
  - ball_run rises one cycle after the state register enters PLAY.
  - score/lives change one cycle after the qualifying edge is seen.
- Boundaries:
  - score never exceeds SCORE_MAX; lives never underflows below 0.
  - frame_tick arriving in the same cycle as a state change is not counted toward the new state.
  - Reset asserted mid-game aborts immediately to the reset values; there is no pending ball_rst afterwards.

Optional Feature:
- Macro: GAME_FLOW_HISCORE_EN.
- When defined:
  - Adds output hiscore[3:0], reset to 0.
  - On entry to OVER or WIN, if score > hiscore then hiscore = score; this updates one cycle after entry.
  - hiscore survives restarts and clears only on rst_n.
- When undefined: no hiscore port or register. All other behaviour is identical.

Test Plan:
1. rst_n low then high, start_btn pulse -> ball_rst=1 for exactly 1 cycle; state=SERVE; score=0, lives=3; after 60 frame_ticks, state=PLAY and ball_run=1.
2. In PLAY, hit held high 50 cycles, then three separate hit pulses -> score ends at 4, not 53; lives stays 3.
3. In PLAY with lives=3, miss pulse -> lives=2, state=MISS, ball_run=0; after 90 frame_ticks, state=SERVE plus a ball_rst pulse; score unchanged.
4. hit and miss rise in the same cycle with score=2, lives=2 -> score=2, lives=1, state=MISS.
5. Eight hits then a ninth hit (SCORE_MAX=9) -> score=9, state=WIN, win=1, game_over=1. A further hit has no effect. start_btn -> score=0, lives=3, SERVE.
6. Lives driven to 0 by three misses -> state=OVER, game_over=1, win=0. rst_n pulsed low mid-SERVE -> all outputs return to reset values immediately. With GAME_FLOW_HISCORE_EN defined, hiscore holds the prior game's score across the restart and reads 0 after rst_n.

Source files
------------

// File: rtl/game_flow_ctrl.sv
// rtl/game_flow_ctrl.sv - pong game sequencer: score/lives counters and serve/play/miss/over flow
// Optional high-score register is enabled by defining GAME_FLOW_HISCORE_EN.
module game_flow_ctrl #(
  parameter int LIVES_INIT   = 3,
  parameter int SCORE_MAX    = 9,
  parameter int SERVE_FRAMES = 60,
  parameter int MISS_FRAMES  = 90
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       frame_tick,
  input  logic       start_btn,
  input  logic       hit,
  input  logic       miss,
  output logic [3:0] score,
  output logic [1:0] lives,
  output logic       ball_run,
  output logic       ball_rst,
  output logic       game_over,
  output logic       win,
  output logic [2:0] state
`ifdef GAME_FLOW_HISCORE_EN
  ,
  output logic [3:0] hiscore
`endif
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SERVE = 3'd1,
    S_PLAY  = 3'd2,
    S_MISS  = 3'd3,
    S_OVER  = 3'd4,
    S_WIN   = 3'd5
  } state_e;

  localparam int CNT_MAX = (SERVE_FRAMES > MISS_FRAMES) ? SERVE_FRAMES : MISS_FRAMES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  localparam logic [CNT_W-1:0] SERVE_LAST = CNT_W'(SERVE_FRAMES - 1);
  localparam logic [CNT_W-1:0] MISS_LAST  = CNT_W'(MISS_FRAMES - 1);
  localparam logic [3:0]       SCORE_TOP  = 4'(SCORE_MAX);
  localparam logic [3:0]       SCORE_PEN  = 4'(SCORE_MAX - 1);
  localparam logic [1:0]       LIVES_RST  = 2'(LIVES_INIT);

  state_e           state_q, state_d;
  logic [3:0]       score_q, score_d;
  logic [1:0]       lives_q, lives_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ball_rst_q, ball_rst_d;
  logic             ball_run_q, game_over_q, win_q;
  logic             start_q, hit_q, miss_q;
  logic             start_ev, hit_ev, miss_ev;
  logic             restart;

  assign start_ev = start_btn & ~start_q;
  assign hit_ev   = hit & ~hit_q;
  assign miss_ev  = miss & ~miss_q;

  always_comb begin
    state_d    = state_q;
    score_d    = score_q;
    lives_d    = lives_q;
    cnt_d      = cnt_q;
    ball_rst_d = 1'b0;
    restart    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start_ev) restart = 1'b1;
      end
      S_SERVE: begin
        if (frame_tick) begin
          if (cnt_q == SERVE_LAST) state_d = S_PLAY;
          else                     cnt_d   = cnt_q + 1'b1;
        end
      end
      S_PLAY: begin
        // A simultaneous hit is dropped when the ball is missed.
        if (miss_ev) begin
          if (lives_q != 2'd0) lives_d = lives_q - 1'b1;
          state_d = (lives_q <= 2'd1) ? S_OVER : S_MISS;
        end else if (hit_ev) begin
          if (score_q < SCORE_PEN) begin
            score_d = score_q + 1'b1;
          end else begin
            score_d = SCORE_TOP;
            state_d = S_WIN;
          end
        end
      end
      S_MISS: begin
        if (frame_tick) begin
          if (cnt_q == MISS_LAST) begin
            state_d    = S_SERVE;
            ball_rst_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 1'b1;
          end
        end
      end
      S_OVER, S_WIN: begin
        if (start_ev) restart = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    if (restart) begin
      state_d    = S_SERVE;
      score_d    = 4'd0;
      lives_d    = LIVES_RST;
      ball_rst_d = 1'b1;
    end

    // Every state change restarts the frame counter, so a coincident tick is never carried over.
    if (state_d != state_q) cnt_d = '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_IDLE;
      score_q     <= 4'd0;
      lives_q     <= LIVES_RST;
      cnt_q       <= '0;
      ball_rst_q  <= 1'b0;
      ball_run_q  <= 1'b0;
      game_over_q <= 1'b0;
      win_q       <= 1'b0;
      start_q     <= 1'b0;
      hit_q       <= 1'b0;
      miss_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      score_q     <= score_d;
      lives_q     <= lives_d;
      cnt_q       <= cnt_d;
      ball_rst_q  <= ball_rst_d;
      ball_run_q  <= (state_q == S_PLAY);
      game_over_q <= (state_d == S_OVER) || (state_d == S_WIN);
      win_q       <= (state_d == S_WIN);
      start_q     <= start_btn;
      hit_q       <= hit;
      miss_q      <= miss;
    end
  end

  assign score     = score_q;
  assign lives     = lives_q;
  assign ball_run  = ball_run_q;
  assign ball_rst  = ball_rst_q;
  assign game_over = game_over_q;
  assign win       = win_q;
  assign state     = state_q;

`ifdef GAME_FLOW_HISCORE_EN
  logic [3:0] hiscore_q;

  // Score is frozen in OVER/WIN, so comparing every cycle there equals an update on entry.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hiscore_q <= 4'd0;
    end else if (((state_q == S_OVER) || (state_q == S_WIN)) && (score_q > hiscore_q)) begin
      hiscore_q <= score_q;
    end
  end

  assign hiscore = hiscore_q;
`endif

endmodule

// File: tb/tb_game_flow_ctrl.sv
// tb/tb_game_flow_ctrl.sv - scoreboard bench for game_flow_ctrl
// Hiscore checks are compiled in when GAME_FLOW_HISCORE_EN is defined.
module tb_game_flow_ctrl;

  localparam int ST_IDLE  = 0;
  localparam int ST_SERVE = 1;
  localparam int ST_PLAY  = 2;
  localparam int ST_MISS  = 3;
  localparam int ST_OVER  = 4;
  localparam int ST_WIN   = 5;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       frame_tick = 1'b0;
  logic       start_btn = 1'b0;
  logic       hit = 1'b0;
  logic       miss = 1'b0;
  logic [3:0] score;
  logic [1:0] lives;
  logic       ball_run;
  logic       ball_rst;
  logic       game_over;
  logic       win;
  logic [2:0] state;
`ifdef GAME_FLOW_HISCORE_EN
  logic [3:0] hiscore;
`endif

  game_flow_ctrl #(
    .LIVES_INIT(3), .SCORE_MAX(9), .SERVE_FRAMES(60), .MISS_FRAMES(90)
  ) dut (
    .clk(clk), .rst_n(rst_n), .frame_tick(frame_tick), .start_btn(start_btn),
    .hit(hit), .miss(miss), .score(score), .lives(lives), .ball_run(ball_run),
    .ball_rst(ball_rst), .game_over(game_over), .win(win), .state(state)
`ifdef GAME_FLOW_HISCORE_EN
    , .hiscore(hiscore)
`endif
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] score;
    logic [1:0] lives;
    logic [2:0] st;
    logic       run;
    logic       rst;
    logic       go;
    logic       win;
  } snap_t;

  snap_t exp_q[$];
  snap_t got_q[$];
  string tag_q[$];
  int    tests_run = 0;
  int    tests_failed = 0;

  function automatic snap_t mk(input int sc, input int lv, input int st,
                               input bit run, input bit rst, input bit go, input bit w);
    snap_t s;
    s.score = 4'(sc); s.lives = 2'(lv); s.st = 3'(st);
    s.run = run; s.rst = rst; s.go = go; s.win = w;
    return s;
  endfunction

  function automatic snap_t sample();
    snap_t s;
    s.score = score; s.lives = lives; s.st = state;
    s.run = ball_run; s.rst = ball_rst; s.go = game_over; s.win = win;
    return s;
  endfunction

  function automatic string fmt(input snap_t s);
    return $sformatf("score=%0d lives=%0d state=%0d run=%b rst=%b over=%b win=%b",
                     s.score, s.lives, s.st, s.run, s.rst, s.go, s.win);
  endfunction

  task automatic push_exp(input string tag, input snap_t e);
    exp_q.push_back(e);
    tag_q.push_back(tag);
  endtask

  task automatic capture();
    got_q.push_back(sample());
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic tick_frames(input int n);
    for (int i = 0; i < n; i++) begin
      frame_tick = 1'b1; cyc(1);
      frame_tick = 1'b0; cyc(1);
    end
  endtask

  task automatic pulse_hit(input int n);
    for (int i = 0; i < n; i++) begin
      hit = 1'b1; cyc(1);
      hit = 1'b0; cyc(1);
    end
  endtask

  task automatic pulse_miss();
    miss = 1'b1; cyc(1);
    miss = 1'b0; cyc(1);
  endtask

  task automatic new_game();
    rst_n = 1'b0; start_btn = 1'b0; hit = 1'b0; miss = 1'b0; frame_tick = 1'b0;
    cyc(1);
    rst_n = 1'b1; start_btn = 1'b1; cyc(1);
    start_btn = 1'b0;
    tick_frames(60);
  endtask

  task automatic test_reset();
    rst_n = 1'b0; cyc(2);
    push_exp("reset_values", mk(0, 3, ST_IDLE, 0, 0, 0, 0)); capture();
    rst_n = 1'b1; cyc(3);
    push_exp("idle_hold", mk(0, 3, ST_IDLE, 0, 0, 0, 0)); capture();
    while (exp_q.size() != 0) begin
      snap_t e, g; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL %s: no output captured", t); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin tests_failed++; $display("FAIL %s: got %s, expected %s", t, fmt(g), fmt(e)); end
      end
    end
  endtask

  task automatic test_serve();
    push_exp("start_event", mk(0, 3, ST_SERVE, 0, 1, 0, 0));
    start_btn = 1'b1; frame_tick = 1'b1; cyc(1); capture();
    push_exp("ball_rst_one_cycle", mk(0, 3, ST_SERVE, 0, 0, 0, 0));
    start_btn = 1'b0; frame_tick = 1'b0; cyc(1); capture();
    tick_frames(30);
    hit = 1'b1; miss = 1'b1; start_btn = 1'b1; cyc(1);
    hit = 1'b0; miss = 1'b0; start_btn = 1'b0; cyc(1);
    push_exp("serve_after_59", mk(0, 3, ST_SERVE, 0, 0, 0, 0));
    tick_frames(29); capture();
    push_exp("serve_after_60", mk(0, 3, ST_PLAY, 0, 0, 0, 0));
    frame_tick = 1'b1; cyc(1); capture();
    push_exp("ball_run_rise", mk(0, 3, ST_PLAY, 1, 0, 0, 0));
    frame_tick = 1'b0; cyc(1); capture();
    while (exp_q.size() != 0) begin
      snap_t e, g; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL %s: no output captured", t); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin tests_failed++; $display("FAIL %s: got %s, expected %s", t, fmt(g), fmt(e)); end
      end
    end
  endtask

  task automatic test_hit_hold();
    push_exp("hit_held_counts_once", mk(1, 3, ST_PLAY, 1, 0, 0, 0));
    hit = 1'b1; cyc(50); hit = 1'b0; cyc(1); capture();
    push_exp("three_more_hits", mk(4, 3, ST_PLAY, 1, 0, 0, 0));
    pulse_hit(3); capture();
    while (exp_q.size() != 0) begin
      snap_t e, g; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL %s: no output captured", t); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin tests_failed++; $display("FAIL %s: got %s, expected %s", t, fmt(g), fmt(e)); end
      end
    end
  endtask

  task automatic test_miss();
    push_exp("miss_edge", mk(4, 2, ST_MISS, 1, 0, 0, 0));
    miss = 1'b1; cyc(1); capture();
    push_exp("ball_run_fall", mk(4, 2, ST_MISS, 0, 0, 0, 0));
    miss = 1'b0; cyc(1); capture();
    push_exp("miss_after_89", mk(4, 2, ST_MISS, 0, 0, 0, 0));
    tick_frames(89); capture();
    push_exp("reserve_pulse", mk(4, 2, ST_SERVE, 0, 1, 0, 0));
    frame_tick = 1'b1; cyc(1); capture();
    frame_tick = 1'b0; cyc(1);
    push_exp("replay", mk(4, 2, ST_PLAY, 1, 0, 0, 0));
    tick_frames(60); capture();
    while (exp_q.size() != 0) begin
      snap_t e, g; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL %s: no output captured", t); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin tests_failed++; $display("FAIL %s: got %s, expected %s", t, fmt(g), fmt(e)); end
      end
    end
  endtask

  task automatic test_hit_miss_same();
    new_game();
    pulse_hit(2);
    pulse_miss();
    tick_frames(90);
    push_exp("setup_s2_l2", mk(2, 2, ST_PLAY, 1, 0, 0, 0));
    tick_frames(60); capture();
    push_exp("miss_beats_hit", mk(2, 1, ST_MISS, 1, 0, 0, 0));
    hit = 1'b1; miss = 1'b1; cyc(1); capture();
    hit = 1'b0; miss = 1'b0; cyc(1);
    while (exp_q.size() != 0) begin
      snap_t e, g; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL %s: no output captured", t); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin tests_failed++; $display("FAIL %s: got %s, expected %s", t, fmt(g), fmt(e)); end
      end
    end
  endtask

  task automatic test_win();
    new_game();
    push_exp("eight_hits", mk(8, 3, ST_PLAY, 1, 0, 0, 0));
    pulse_hit(8); capture();
    push_exp("ninth_hit_win", mk(9, 3, ST_WIN, 1, 0, 1, 1));
    hit = 1'b1; cyc(1); capture();
    push_exp("win_settled", mk(9, 3, ST_WIN, 0, 0, 1, 1));
    hit = 1'b0; cyc(1); capture();
    push_exp("extra_hit_ignored", mk(9, 3, ST_WIN, 0, 0, 1, 1));
    pulse_hit(1); capture();
    push_exp("restart_from_win", mk(0, 3, ST_SERVE, 0, 1, 0, 0));
    start_btn = 1'b1; cyc(1); capture();
    start_btn = 1'b0; cyc(1);
`ifdef GAME_FLOW_HISCORE_EN
    tests_run++;
    if (hiscore !== 4'd9) begin
      tests_failed++; $display("FAIL hiscore_after_win: got %0d, expected 9", hiscore);
    end
`endif
    while (exp_q.size() != 0) begin
      snap_t e, g; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL %s: no output captured", t); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin tests_failed++; $display("FAIL %s: got %s, expected %s", t, fmt(g), fmt(e)); end
      end
    end
  endtask

  task automatic test_over_reset();
    new_game();
    pulse_hit(2);
    for (int r = 0; r < 2; r++) begin
      pulse_miss();
      tick_frames(90);
      tick_frames(60);
    end
    push_exp("third_miss_over", mk(2, 0, ST_OVER, 1, 0, 1, 0));
    miss = 1'b1; cyc(1); capture();
    push_exp("over_settled", mk(2, 0, ST_OVER, 0, 0, 1, 0));
    miss = 1'b0; cyc(1); capture();
`ifdef GAME_FLOW_HISCORE_EN
    tests_run++;
    if (hiscore !== 4'd2) begin
      tests_failed++; $display("FAIL hiscore_on_over: got %0d, expected 2", hiscore);
    end
`endif
    push_exp("restart_from_over", mk(0, 3, ST_SERVE, 0, 1, 0, 0));
    start_btn = 1'b1; cyc(1); capture();
    start_btn = 1'b0;
    tick_frames(10);
`ifdef GAME_FLOW_HISCORE_EN
    tests_run++;
    if (hiscore !== 4'd2) begin
      tests_failed++; $display("FAIL hiscore_across_restart: got %0d, expected 2", hiscore);
    end
`endif
    push_exp("async_reset_mid_serve", mk(0, 3, ST_IDLE, 0, 0, 0, 0));
    rst_n = 1'b0; #1; capture();
`ifdef GAME_FLOW_HISCORE_EN
    tests_run++;
    if (hiscore !== 4'd0) begin
      tests_failed++; $display("FAIL hiscore_after_reset: got %0d, expected 0", hiscore);
    end
`endif
    cyc(1);
    rst_n = 1'b1;
    push_exp("no_pending_ball_rst", mk(0, 3, ST_IDLE, 0, 0, 0, 0));
    cyc(1); capture();
    while (exp_q.size() != 0) begin
      snap_t e, g; string t;
      e = exp_q.pop_front(); t = tag_q.pop_front(); tests_run++;
      if (got_q.size() == 0) begin tests_failed++; $display("FAIL %s: no output captured", t); end
      else begin
        g = got_q.pop_front();
        if (g !== e) begin tests_failed++; $display("FAIL %s: got %s, expected %s", t, fmt(g), fmt(e)); end
      end
    end
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_serve();
    test_hit_hold();
    test_miss();
    test_hit_miss_same();
    test_win();
    test_over_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
